rram_addr_seq: RTL and testbench

Address sequencer downstream of the SPI register array. On an FSM start it walks the word address from `address_start` to `address_stop` in increments of `address_step`, one address per FSM advance request. It flags the final address, optionally loops forever, and presents a registered address to the RRAM array driver. It owns all address arithmetic and wrap/stop detection, so the FSM only issues `start`, `next` and `abort`.

---
 rtl/rram_addr_seq_if.sv | 29 ++
 rtl/rram_addr_seq.sv | 118 +++++++++++
 tb/tb_rram_addr_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rram_addr_seq_if.sv
// rram_addr_seq_if: FSM-facing control, configuration and address bus of rram_addr_seq
// master: FSM side (drives start/abort/next and configuration); slave: the sequencer
interface rram_addr_seq_if #(
  parameter int ADDR_BITS_N = 16,
  parameter int LOOP_CNT_BITS_N = 16
);
  logic start;
  logic abort;
  logic next;
  logic use_multi_addrs;
  logic loop_mode;
  logic [ADDR_BITS_N-1:0] address_start;
  logic [ADDR_BITS_N-1:0] address_stop;
  logic [ADDR_BITS_N-1:0] address_step;
  logic [ADDR_BITS_N-1:0] addr;
  logic addr_valid;
  logic last;
  logic busy;
  logic done;
  logic [LOOP_CNT_BITS_N-1:0] loop_count;
  modport master(
    output start, abort, next, use_multi_addrs, loop_mode, address_start, address_stop, address_step,
    input addr, addr_valid, last, busy, done, loop_count
  );
  modport slave(
    input start, abort, next, use_multi_addrs, loop_mode, address_start, address_stop, address_step,
    output addr, addr_valid, last, busy, done, loop_count
  );
endinterface

// File: rtl/rram_addr_seq.sv
// rram_addr_seq: walks the RRAM word address start..stop by step, one address per next request
// Ports: sclk (clock), rst (async active-high reset), bus (rram_addr_seq_if.slave: start/abort/next,
// configuration in, registered addr/addr_valid/last/busy/done/loop_count out).
// Define RRAM_ADDR_SEQ_LOOP_EN to enable loop mode and the loop_count counter.
module rram_addr_seq #(
  parameter int ADDR_BITS_N = 16,
  parameter int LOOP_CNT_BITS_N = 16
) (
  input logic sclk,
  input logic rst,
  rram_addr_seq_if.slave bus
);
  localparam int A = ADDR_BITS_N;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [A-1:0] addr_q, addr_nxt, start_q, start_nxt, stop_q, stop_nxt, step_q, step_nxt, step_in;
  logic multi_q, multi_nxt, valid_q, valid_nxt, last_q, last_nxt, loop_q, go, reload;
  logic [A:0] sum;
  // a is the final address when the following one would pass stop (checked without overflow)
  function automatic logic last_at(input logic multi, input logic [A-1:0] a, st, sp);
    return !multi || (({1'b0, a} + {1'b0, st}) > {1'b0, sp});
  endfunction
  assign step_in = (bus.address_step == '0) ? A'(1) : bus.address_step;
  assign sum = {1'b0, addr_q} + {1'b0, step_q};
  always_comb begin
    state_nxt = state;
    addr_nxt = addr_q;
    valid_nxt = valid_q;
    last_nxt = last_q;
    start_nxt = start_q;
    stop_nxt = stop_q;
    step_nxt = step_q;
    multi_nxt = multi_q;
    go = 1'b0;
    reload = 1'b0;
    if (bus.abort) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
      last_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          go = 1'b1;
          state_nxt = RUN;
          start_nxt = bus.address_start;
          stop_nxt = bus.address_stop;
          step_nxt = step_in;
          multi_nxt = bus.use_multi_addrs;
          addr_nxt = bus.address_start;
          valid_nxt = 1'b1;
          last_nxt = last_at(bus.use_multi_addrs, bus.address_start, step_in, bus.address_stop);
        end
        RUN: if (bus.next && valid_q) begin
          if (!last_q) begin
            addr_nxt = sum[A-1:0];
            last_nxt = sum[A] || last_at(1'b1, sum[A-1:0], step_q, stop_q);
          end else if (loop_q) begin
            reload = 1'b1;
            addr_nxt = start_q;
            last_nxt = last_at(multi_q, start_q, step_q, stop_q);
          end else begin
            state_nxt = DONE;
            valid_nxt = 1'b0;
            last_nxt = 1'b0;
          end
        end
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      start_q <= '0;
      stop_q <= '0;
      step_q <= '0;
      multi_q <= 1'b0;
    end else begin
      state <= state_nxt;
      addr_q <= addr_nxt;
      valid_q <= valid_nxt;
      last_q <= last_nxt;
      start_q <= start_nxt;
      stop_q <= stop_nxt;
      step_q <= step_nxt;
      multi_q <= multi_nxt;
    end
  end
`ifdef RRAM_ADDR_SEQ_LOOP_EN
  logic [LOOP_CNT_BITS_N-1:0] cnt;
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      loop_q <= 1'b0;
      cnt <= '0;
    end else if (go) begin
      loop_q <= bus.loop_mode;
      cnt <= '0;
    end else if (reload && !(&cnt)) begin
      cnt <= cnt + LOOP_CNT_BITS_N'(1);
    end
  end
  assign bus.loop_count = cnt;
`else
  logic [2:0] unused_loop;
  assign loop_q = 1'b0;
  assign unused_loop = {bus.loop_mode, reload, go};
  assign bus.loop_count = '0;
`endif
  assign bus.addr = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.last = last_q;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_rram_addr_seq.sv
// tb_rram_addr_seq: scoreboard bench for rram_addr_seq
module tb_rram_addr_seq;
  logic sclk = 1'b0;
  logic rst = 1'b1;
  always #5 sclk = ~sclk;
  rram_addr_seq_if bus();
  rram_addr_seq dut(.sclk(sclk), .rst(rst), .bus(bus));
  typedef struct {logic [15:0] a; logic l; int c;} exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge sclk);
    #1;
  endtask
  task automatic push_walk(input int s, input int e, input int st, input bit multi);
    int a;
    int stp;
    bit l;
    a = s;
    stp = (st == 0) ? 1 : st;
    forever begin
      l = !multi || (a + stp > e);
      q.push_back('{a[15:0], l, 0});
      if (l) break;
      a += stp;
    end
  endtask
  task automatic start_seq(input int s, input int e, input int st, input bit multi, input bit lp);
    bus.address_start = s[15:0];
    bus.address_stop = e[15:0];
    bus.address_step = st[15:0];
    bus.use_multi_addrs = multi;
    bus.loop_mode = lp;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.address_start = 16'($urandom);
    bus.address_stop = 16'($urandom);
    bus.address_step = 16'($urandom);
    bus.use_multi_addrs = ~multi;
    check("start busy", bus.busy, 1);
    check("start valid", bus.addr_valid, 1);
    check("start cnt", bus.loop_count, 0);
  endtask
  task automatic drain(input string name);
    int guard;
    exp_t e;
    guard = 0;
    bus.next = 1'b1;
    while (q.size() > 0 && guard < 64) begin
      e = q.pop_front();
      check({name, " addr"}, bus.addr, e.a);
      check({name, " last"}, bus.last, e.l);
      check({name, " valid"}, bus.addr_valid, 1);
      check({name, " nodone"}, bus.done, 0);
      tick;
      guard++;
    end
    bus.next = 1'b0;
    check({name, " left"}, q.size(), 0);
    check({name, " done"}, bus.done, 1);
    check({name, " busy"}, bus.busy, 1);
    check({name, " offvalid"}, bus.addr_valid, 0);
    tick;
    check({name, " done1"}, bus.done, 0);
    check({name, " idle"}, bus.busy, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 300000");
    $fatal(1);
  end
  initial begin
    exp_t e;
    bus.start = 0;
    bus.abort = 0;
    bus.next = 0;
    bus.use_multi_addrs = 0;
    bus.loop_mode = 0;
    bus.address_start = 0;
    bus.address_stop = 0;
    bus.address_step = 0;
    repeat (2) tick;
    check("rst addr", bus.addr, 0);
    check("rst valid", bus.addr_valid, 0);
    check("rst last", bus.last, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst cnt", bus.loop_count, 0);
    rst = 1'b0;
    tick;
    push_walk(5, 16'h100, 1, 0);
    start_seq(5, 16'h100, 1, 0, 0);
    drain("single");
    push_walk(16'h10, 16'h18, 4, 1);
    start_seq(16'h10, 16'h18, 4, 1, 0);
    drain("walk");
    push_walk(3, 5, 0, 1);
    start_seq(3, 5, 0, 1, 0);
    drain("step0");
    push_walk(7, 3, 1, 1);
    start_seq(7, 3, 1, 1, 0);
    drain("rev");
    push_walk(16'hFFF0, 16'hFFFF, 16'h20, 1);
    start_seq(16'hFFF0, 16'hFFFF, 16'h20, 1, 0);
    drain("top");
`ifdef RRAM_ADDR_SEQ_LOOP_EN
    for (int i = 0; i < 7; i++) q.push_back('{16'(i % 3), (i % 3) == 2, i / 3});
    start_seq(0, 2, 1, 1, 1);
    bus.next = 1'b1;
    for (int i = 0; i < 7; i++) begin
      e = q.pop_front();
      check("loop addr", bus.addr, e.a);
      check("loop last", bus.last, e.l);
      check("loop cnt", bus.loop_count, e.c);
      check("loop nodone", bus.done, 0);
      if (i < 6) tick;
    end
    bus.next = 1'b0;
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    check("loop abort busy", bus.busy, 0);
    check("loop cnt held", bus.loop_count, 2);
    tick;
`else
    push_walk(0, 2, 1, 1);
    start_seq(0, 2, 1, 1, 1);
    drain("noloop");
    check("noloop cnt", bus.loop_count, 0);
`endif
    start_seq(0, 16'h20, 1, 1, 0);
    bus.next = 1'b1;
    tick;
    tick;
    bus.next = 1'b0;
    check("ab addr2", bus.addr, 2);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("run start ign addr", bus.addr, 2);
    check("run start ign busy", bus.busy, 1);
    check("run start ign cnt", bus.loop_count, 0);
    bus.abort = 1'b1;
    bus.next = 1'b1;
    tick;
    bus.abort = 1'b0;
    bus.next = 1'b0;
    check("abort valid", bus.addr_valid, 0);
    check("abort last", bus.last, 0);
    check("abort busy", bus.busy, 0);
    check("abort addr", bus.addr, 2);
    check("abort done", bus.done, 0);
    tick;
    check("abort done1", bus.done, 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("st+ab busy", bus.busy, 0);
    check("st+ab valid", bus.addr_valid, 0);
    start_seq(16'h40, 16'h80, 1, 1, 0);
    bus.next = 1'b1;
    tick;
    tick;
    check("pre rst addr", bus.addr, 16'h42);
    #3 rst = 1'b1;
    #1;
    check("async addr", bus.addr, 0);
    check("async valid", bus.addr_valid, 0);
    check("async last", bus.last, 0);
    check("async busy", bus.busy, 0);
    check("async done", bus.done, 0);
    bus.next = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    push_walk(9, 9, 1, 1);
    start_seq(9, 9, 1, 1, 0);
    drain("after rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
